display_latch_scanner: RTL and testbench

- Downstream consumer of the memory decoder's display chip-enable and display offset for the ET-3400 trainer.
- Captures CPU writes to the six-digit, per-segment-addressed display window (C110–C16F) into a 48-bit segment register file.
- Time-multiplexes the six digits onto shared segment pins and one-hot digit enables for the board's 7-segment LEDs.

---
 rtl/et3400_display_pkg.sv | 38 +++
 rtl/display_scan_timer.sv | 58 +++++
 rtl/display_latch_scanner.sv | 97 +++++++++
 tb/tb_display_latch_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/et3400_display_pkg.sv
// ET-3400 display package: digit/segment constants, scan state, helpers.
// Shared by display_scan_timer and display_latch_scanner.
package et3400_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_WIDTH  = 8;

  localparam int SEG_DP = 0;
  localparam int SEG_G  = 1;
  localparam int SEG_F  = 2;
  localparam int SEG_E  = 3;
  localparam int SEG_D  = 4;
  localparam int SEG_C  = 5;
  localparam int SEG_B  = 6;
  localparam int SEG_A  = 7;

  localparam logic [2:0] DIGIT_MIN = 3'd1;
  localparam logic [2:0] DIGIT_MAX = 3'd6;
  localparam logic [2:0] IDX_LAST  = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  typedef logic [SEG_WIDTH-1:0] seg_t;

  function automatic logic digit_valid(input logic [2:0] d);
    return (d >= DIGIT_MIN) && (d <= DIGIT_MAX);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(
    input logic [2:0] idx
  );
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Digit-slot timer: divider, BLANK/ON state machine and digit index.
// Each slot is BLANK_CYCLES blank cycles followed by the lit period.
module display_scan_timer
  import et3400_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] idx_o,
  output logic       on_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);

  scan_state_e   state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;

  // State, divider and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  // Slot sequencing: blank phase, lit phase, advance digit at slot end
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      state_d = BLANK;
      idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      div_d = div_q + 1'b1;
      unique case (state_q)
        BLANK: if (div_q == BLANK_LAST) state_d = ON;
        ON:    state_d = ON;
        default: state_d = BLANK;
      endcase
    end
  end

  assign idx_o = idx_q;
  assign on_o  = (state_q == ON);

endmodule

// File: rtl/display_latch_scanner.sv
// ET-3400 display latch + multiplexed scanner for window C110-C16F.
// Define DISPLAY_READBACK_EN to let the CPU read back segment bits.
module display_latch_scanner
  import et3400_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  CE_DISPLAY,
  input  logic [6:0]            DISP_ADDRESS,
  input  logic                  Rw,
  input  logic [7:0]            Data_In,
  output logic [7:0]            Data_Out,
  output logic [SEG_WIDTH-1:0]  Segments,
  output logic [NUM_DIGITS-1:0] Digit_En
);

  logic                  ce_q;
  seg_t                  regs_q [NUM_DIGITS];
  seg_t                  regs_d [NUM_DIGITS];
  seg_t                  segments_q, segments_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  logic [2:0] dfield;
  logic [2:0] widx;
  logic [2:0] sbit;
  logic [2:0] scan_idx;
  logic       scan_on;
  logic       dvalid;
  logic       wr_fire;
  logic       unused_ok;

  assign dfield  = DISP_ADDRESS[6:4];
  assign sbit    = DISP_ADDRESS[2:0];
  assign dvalid  = digit_valid(dfield);
  assign widx    = dfield - 3'd1;
  assign wr_fire = CE_DISPLAY & ~ce_q & ~Rw & dvalid;

  // Mirror bit and upper data bits carry no meaning here
  assign unused_ok = ^{Data_In[7:1], DISP_ADDRESS[3]};

  display_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk   (Clock),
    .rst_n (Reset_n),
    .idx_o (scan_idx),
    .on_o  (scan_on)
  );

  // One write per CE rising edge into the addressed segment bit
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) regs_d[i] = regs_q[i];
    if (wr_fire) regs_d[widx][sbit] = Data_In[0];
  end

  // Drive the lit digit from the register file, dark while blanking
  always_comb begin
    segments_d = '0;
    digit_en_d = '0;
    if (scan_on) begin
      segments_d = regs_q[scan_idx];
      digit_en_d = digit_onehot(scan_idx);
    end
  end

  // CE sample, register file and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ce_q       <= 1'b0;
      segments_q <= '0;
      digit_en_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) regs_q[i] <= '0;
    end else begin
      ce_q       <= CE_DISPLAY;
      segments_q <= segments_d;
      digit_en_q <= digit_en_d;
      for (int i = 0; i < NUM_DIGITS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // CPU read path; write-only display unless readback is built in
  always_comb begin
    Data_Out = 8'hFF;
`ifdef DISPLAY_READBACK_EN
    if (CE_DISPLAY && Rw && dvalid)
      Data_Out = {7'h7F, regs_q[widx][sbit]};
`endif
  end

  assign Segments = segments_q;
  assign Digit_En = digit_en_q;

endmodule

// File: tb/tb_display_latch_scanner.sv
// Bench for display_latch_scanner: scoreboard of scan outputs plus
// read-path checks against a slot-arithmetic reference model.
module tb_display_latch_scanner;

  localparam int SD = 10;
  localparam int BC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce    = 1'b0;
  logic       rw    = 1'b1;
  logic [6:0] addr  = '0;
  logic [7:0] din   = '0;
  logic [7:0] dout;
  logic [7:0] seg;
  logic [5:0] den;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [5:0] de;
    logic [7:0] sg;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mreg [6] = '{default: 8'h00};
  int         cyc      = 0;
  logic       m_ce_prev = 1'b0;

  display_latch_scanner #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .Clock        (clk),
    .Reset_n      (rst_n),
    .CE_DISPLAY   (ce),
    .DISP_ADDRESS (addr),
    .Rw           (rw),
    .Data_In      (din),
    .Data_Out     (dout),
    .Segments     (seg),
    .Digit_En     (den)
  );

  always #5 clk = ~clk;

  // Reference model: output after edge n shows timer position n-1,
  // i.e. slot (n-1)/SD mod 6, lit when phase >= BC.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0;
      m_ce_prev = 1'b0;
      for (int i = 0; i < 6; i++) mreg[i] = 8'h00;
      q.delete();
    end else begin
      automatic int   slot  = (cyc / SD) % 6;
      automatic int   phase = cyc % SD;
      automatic int   d     = int'(addr[6:4]);
      automatic exp_t e     = '0;
      if (phase >= BC) begin
        e.de = 6'(1 << slot);
        e.sg = mreg[slot];
      end
      q.push_back(e);
      if (ce && !m_ce_prev && !rw && d >= 1 && d <= 6)
        mreg[d-1][addr[2:0]] = din[0];
      m_ce_prev = ce;
      cyc++;
    end
  end

  // Monitor: one expected scan vector per clock while out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        automatic exp_t e = q.pop_front();
        if (den !== e.de || seg !== e.sg) begin
          miscompares++;
          $display("FAIL scan t=%0t: Digit_En=%b Segments=%h, expected %b %h",
                   $time, den, seg, e.de, e.sg);
        end
      end
    end
  end

  function automatic logic [7:0] exp_dout();
    automatic int d = int'(addr[6:4]);
    logic [7:0] r;
    r = 8'hFF;
`ifdef DISPLAY_READBACK_EN
    if (ce && rw && d >= 1 && d <= 6)
      r = {7'h7F, mreg[d-1][addr[2:0]]};
`else
    if (d < 0) r = 8'h00;
`endif
    return r;
  endfunction

  task automatic check_dout(input string name);
    logic [7:0] e;
    e = exp_dout();
    vectors++;
    if (dout !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t: Data_Out=%h, expected %h", name, $time, dout, e);
    end
  endtask

  task automatic check_dark(input string name);
    vectors++;
    if (den !== 6'b0 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL %s t=%0t: Digit_En=%b Segments=%h, expected 0 0",
               name, $time, den, seg);
    end
  endtask

  task automatic access(input logic [6:0] a, input logic r,
                        input logic [7:0] d, input int hold,
                        input int gap, input bit togg);
    @(negedge clk);
    addr = a;
    rw   = r;
    din  = d;
    ce   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1 check_dout("read_data");
      @(negedge clk);
      if (togg) din = 8'($urandom);
    end
    ce = 1'b0;
    for (int i = 0; i < gap; i++) begin
      #1 check_dout("idle_data");
      @(negedge clk);
      din  = 8'($urandom);
      addr = 7'($urandom);
      rw   = 1'($urandom);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_dark("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1 check_dark("reset_state");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    access(7'h67, 1'b0, 8'h01, 1, 3, 1'b0);
    repeat (70) @(negedge clk);

    access(7'h25, 1'b0, 8'h01, 20, 3, 1'b1);
    access(7'h31, 1'b0, 8'h00, 20, 3, 1'b1);
    access(7'h03, 1'b0, 8'h01, 1, 2, 1'b0);
    access(7'h73, 1'b0, 8'h01, 1, 2, 1'b0);
    access(7'h0F, 1'b0, 8'h01, 4, 2, 1'b0);
    access(7'h18, 1'b0, 8'h01, 1, 2, 1'b0);
    access(7'h18, 1'b1, 8'h00, 3, 2, 1'b0);
    access(7'h19, 1'b1, 8'h00, 3, 2, 1'b0);
    access(7'h78, 1'b1, 8'h00, 2, 2, 1'b0);
    repeat (70) @(negedge clk);

    // Reset while digit 3 is lit
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((cyc / SD) % 6 == 3 && cyc % SD == 5) break;
    end
    #2 rst_n = 1'b0;
    #1 check_dark("reset_mid_on");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (70) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(39) == 0) reset_pulse();
      access(7'($urandom), 1'($urandom), 8'($urandom),
             $urandom_range(20, 1), $urandom_range(6, 1), 1'($urandom));
    end
    repeat (70) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
